// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit: one request in flight, word-addressed data memory with
// 1-cycle read latency, aligned and extended load data back to writeback.
module ysyx_23060180_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                wen_q, uns_q, err_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, data_q, load_ext;
  logic [4:0]          rd_q;
  logic                illegal;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;

  // Classify the incoming request as misaligned or illegally encoded
  always_comb begin
    illegal = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || (req_unsigned && (req_size == 2'b10 || req_wen));
  end

  // Pick the addressed byte/half from the returned word and extend it
  always_comb begin
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(DATA_W-8){1'b0}}, lane_b}
                                : {{(DATA_W-8){lane_b[7]}}, lane_b};
      2'b01:   load_ext = uns_q ? {{(DATA_W-16){1'b0}}, lane_h}
                                : {{(DATA_W-16){lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request latch on accept; load data capture in RWAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      wen_q   <= req_wen;
      uns_q   <= req_unsigned;
      err_q   <= illegal;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rd_q    <= req_rd;
      data_q  <= '0;
    end else if (state_q == S_RWAIT) begin
      data_q  <= load_ext;
    end
  end

  // Next state and all outputs, decoded from the current state only
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_rd    = '0;
    resp_err   = 1'b0;
    mem_rd     = 1'b0;
    mem_raddr  = '0;
    mem_wr     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (illegal)      state_d = S_RESP;
          else if (req_wen) state_d = S_WR;
          else              state_d = S_RD;
        end
      end
      S_RD: begin
        mem_rd    = 1'b1;
        mem_raddr = {addr_q[ADDR_W-1:2], 2'b00};
        state_d   = S_RWAIT;
      end
      S_RWAIT: state_d = S_RESP;
      S_WR: begin
        mem_wr    = 1'b1;
        mem_waddr = {addr_q[ADDR_W-1:2], 2'b00};
        case (size_q)
          2'b00: begin
            mem_wmask = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            mem_wmask = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_wmask = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = data_q;
        resp_rd    = (wen_q || err_q) ? 5'd0 : rd_q;
        resp_err   = err_q;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Directed bench for the load/store unit with a small word memory model.
module tb_ysyx_23060180_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_23060180_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  // Word memory: read data appears the cycle after mem_rd; masked writes.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_raddr[9:2]];
    if (mem_wr)
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) mem[mem_waddr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations from the last transaction
  logic [31:0] r_rdata, r_raddr, r_waddr, r_wdata;
  logic [4:0]  r_rd;
  logic [3:0]  r_wmask;
  logic        r_err;
  int          r_lat, r_nrd, r_nwr, r_rd_at, r_both;

  // Issue one request, then follow it cycle by cycle until resp_valid (bounded).
  task automatic run(input logic wen, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dst);
    @(negedge clk);
    req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = dst; req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen = ~wen; req_size = ~size; req_unsigned = ~uns;
    req_addr = addr ^ 32'h0000_00ff; req_wdata = ~wdata; req_rd = ~dst;
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_rd_at = 0; r_both = 0;
    r_raddr = '0; r_waddr = '0; r_wdata = '0; r_wmask = '0;
    r_rdata = '0; r_rd = '0; r_err = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (mem_rd) begin r_nrd++; r_rd_at = k; r_raddr = mem_raddr; end
      if (mem_wr) begin r_nwr++; r_waddr = mem_waddr; r_wdata = mem_wdata; r_wmask = mem_wmask; end
      if (mem_rd && mem_wr) r_both++;
      if (resp_valid) begin
        r_lat = k; r_rdata = resp_rdata; r_rd = resp_rd; r_err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    check("strobes_overlap", r_both, 0);
  endtask

  task automatic finish_resp(input string tag);
    @(posedge clk); #1;
    check({tag, "_resp_drop"}, resp_valid, 0);
    check({tag, "_ready_back"}, req_ready, 1);
  endtask

  task automatic expect_load(input string tag, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [4:0] dst, input logic [31:0] exp);
    run(1'b0, size, uns, addr, 32'h5a5a_5a5a, dst);
    check({tag, "_lat"}, r_lat, 3);
    check({tag, "_nrd"}, r_nrd, 1);
    check({tag, "_rd_at"}, r_rd_at, 1);
    check({tag, "_nwr"}, r_nwr, 0);
    check({tag, "_raddr"}, r_raddr, {addr[31:2], 2'b00});
    check({tag, "_rdata"}, r_rdata, exp);
    check({tag, "_rd"}, r_rd, dst);
    check({tag, "_err"}, r_err, 0);
    finish_resp(tag);
  endtask

  task automatic expect_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask, input logic [31:0] wexp);
    run(1'b1, size, 1'b0, addr, wdata, 5'd3);
    check({tag, "_lat"}, r_lat, 2);
    check({tag, "_nwr"}, r_nwr, 1);
    check({tag, "_nrd"}, r_nrd, 0);
    check({tag, "_waddr"}, r_waddr, {addr[31:2], 2'b00});
    check({tag, "_wmask"}, r_wmask, mask);
    check({tag, "_wdata"}, r_wdata, wexp);
    check({tag, "_rd"}, r_rd, 0);
    check({tag, "_rdata"}, r_rdata, 0);
    check({tag, "_err"}, r_err, 0);
    finish_resp(tag);
  endtask

  task automatic expect_err(input string tag, input logic wen, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr);
    run(wen, size, uns, addr, 32'h0000_00ff, 5'd4);
    check({tag, "_lat"}, r_lat, 1);
    check({tag, "_nrd"}, r_nrd, 0);
    check({tag, "_nwr"}, r_nwr, 0);
    check({tag, "_err"}, r_err, 1);
    check({tag, "_rdata"}, r_rdata, 0);
    check({tag, "_rd"}, r_rd, 0);
    finish_resp(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h04] = 32'hDEAD_BEEF;
    mem_rdata = '0;
    rst = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    @(negedge clk); rst = 1'b0;

    // Loads from the word 0xDEADBEEF
    expect_load("lw",    2'b10, 1'b0, 32'h8000_0010, 5'd5,  32'hDEAD_BEEF);
    expect_load("lb",    2'b00, 1'b0, 32'h8000_0013, 5'd6,  32'hFFFF_FFDE);
    expect_load("lbu",   2'b00, 1'b1, 32'h8000_0013, 5'd7,  32'h0000_00DE);
    expect_load("lh",    2'b01, 1'b0, 32'h8000_0012, 5'd8,  32'hFFFF_DEAD);
    expect_load("lhu",   2'b01, 1'b1, 32'h8000_0010, 5'd9,  32'h0000_BEEF);
    expect_load("lb0",   2'b00, 1'b0, 32'h8000_0010, 5'd10, 32'hFFFF_FFEF);
    expect_load("lbu1",  2'b00, 1'b1, 32'h8000_0011, 5'd31, 32'h0000_00BE);

    // Stores, then read back merged words
    expect_store("sb",   2'b00, 32'h8000_0021, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    expect_store("sh",   2'b01, 32'h8000_0022, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    expect_load("lw20",  2'b10, 1'b0, 32'h8000_0020, 5'd1,  32'h1234_AB00);
    expect_store("sw",   2'b10, 32'h8000_0024, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    expect_load("lhu26", 2'b01, 1'b1, 32'h8000_0026, 5'd2,  32'h0000_CAFE);
    expect_load("lb24",  2'b00, 1'b0, 32'h8000_0024, 5'd2,  32'h0000_000D);

    // Illegal / misaligned requests
    expect_err("lw_mis",  1'b0, 2'b10, 1'b0, 32'h8000_0002);
    expect_err("lh_mis",  1'b0, 2'b01, 1'b0, 32'h8000_0001);
    expect_err("size11",  1'b0, 2'b11, 1'b0, 32'h8000_0010);
    expect_err("lwu",     1'b0, 2'b10, 1'b1, 32'h8000_0010);
    expect_err("sbu",     1'b1, 2'b00, 1'b1, 32'h8000_0020);
    expect_err("sw_mis",  1'b1, 2'b10, 1'b0, 32'h8000_0022);
    expect_load("lw20b",  2'b10, 1'b0, 32'h8000_0020, 5'd1,  32'h1234_AB00);

    // Backpressure: response held, competing request waits for the handshake
    resp_ready = 1'b0;
    run(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 5'd9);
    check("bp_lat", r_lat, 3);
    check("bp_rdata0", r_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    req_wen = 1'b0; req_size = 2'b00; req_unsigned = 1'b1;
    req_addr = 32'h8000_0013; req_rd = 5'd11; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", resp_valid, 1);
      check("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("bp_rd", resp_rd, 9);
      check("bp_ready", req_ready, 0);
      check("bp_mem_rd", mem_rd, 0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_valid", resp_valid, 0);
    check("bp_hs_ready", req_ready, 1);
    check("bp_hs_mem_rd", mem_rd, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_next_mem_rd", mem_rd, 1);
    check("bp_next_raddr", mem_raddr, 32'h8000_0010);
    repeat (2) begin @(posedge clk); #1; end
    check("bp_next_valid", resp_valid, 1);
    check("bp_next_rdata", resp_rdata, 32'h0000_00DE);
    check("bp_next_rd", resp_rd, 11);
    finish_resp("bp_next");

    // Reset while waiting for read data
    @(negedge clk);
    req_wen = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8000_0020; req_rd = 5'd12; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw_mem_rd", mem_rd, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rw_req_ready", req_ready, 1);
    check("rw_resp_valid", resp_valid, 0);
    check("rw_resp_rdata", resp_rdata, 0);
    check("rw_resp_rd", resp_rd, 0);
    check("rw_resp_err", resp_err, 0);
    check("rw_mem_rd0", mem_rd, 0);
    check("rw_mem_raddr", mem_raddr, 0);
    check("rw_mem_wr", mem_wr, 0);
    check("rw_mem_wmask", mem_wmask, 0);
    @(posedge clk); #1;
    check("rw_hold_valid", resp_valid, 0);
    check("rw_hold_mem_rd", mem_rd, 0);
    @(negedge clk); rst = 1'b0;
    expect_load("rw_lw", 2'b10, 1'b0, 32'h8000_0020, 5'd12, 32'h1234_AB00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
